if_mem_port: RTL and testbench

Instruction-fetch responder between the fetch stage and the byte-wide unified RAM. It accepts one PC request at a time and reads four consecutive bytes over the 8-bit RAM bus. It assembles the bytes into a little-endian instruction word and returns it to fetch with a one-cycle `ok` pulse, the word (`dt`) and its tag PC (`ipc`). It yields the RAM bus to the load/store unit (`ls_busy`), and it abandons in-flight work on a pipeline redirect (`flush`).

---
 rtl/mem_pkg.sv | 15 +
 rtl/word_assembler.sv | 26 ++
 rtl/if_mem_port.sv | 131 +++++++++++++
 tb/tb_if_mem_port.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the RAM-side fetch and load/store ports.
// Byte-wide RAM bus, 32-bit instruction/data words.
package mem_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_e;

  localparam int BYTE_CNT_W = 3;
  localparam int DATA_W     = 8;
  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = WORD_W / DATA_W;

endpackage

// File: rtl/word_assembler.sv
// Collects RAM bytes into a little-endian word, one lane per capture.
// Cleared at the start of each transfer so unwritten lanes read as 0.
module word_assembler
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cap,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] din,
  output logic [WORD_W-1:0] word
);

  // Lane register: clear on a new transfer, else drop din into its lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
    end else if (clr) begin
      word <= '0;
    end else if (cap) begin
      word[{lane, 3'b000} +: DATA_W] <= din;
    end
  end

endmodule

// File: rtl/if_mem_port.sv
// Fetch-side RAM port: reads four bytes from pc, returns one word.
// Yields the bus to load/store and drops in-flight work on flush.
module if_mem_port
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic              flush,
  input  logic              ls_busy,
  input  logic [DATA_W-1:0] mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_rd_en,
  output logic              ok,
  output logic              almost_ok,
  output logic [WORD_W-1:0] dt,
  output logic [ADDR_W-1:0] ipc,
  output logic              busy
);

  localparam logic [BYTE_CNT_W-1:0] CNT_FULL =
    BYTE_CNT_W'(WORD_BYTES);
  localparam logic [BYTE_CNT_W-1:0] CNT_LAST =
    BYTE_CNT_W'(WORD_BYTES - 1);

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_W-1:0]     pc_q;
  logic [BYTE_CNT_W-1:0] issue_cnt;
  logic [BYTE_CNT_W-1:0] rcv_cnt;
  logic                  pend_q;
  logic                  almost_q;
  logic [WORD_W-1:0]     asm_word;

  logic accept;
  logic issue;
  logic cap;
  logic last;

  assign accept = (state_q == ST_IDLE) & req
                & ~flush & ~ls_busy;
  assign issue  = (state_q == ST_FETCH) & ~flush
                & ~ls_busy & (issue_cnt < CNT_FULL);
  // pend_q marks that mem_din carries a byte we asked for.
  assign cap    = pend_q & ~flush;
  assign last   = cap & (rcv_cnt == CNT_LAST);

  // A flush in the final-byte cycle kills the early warning too.
  assign almost_ok = almost_q & ~flush;

  // Next state: leave IDLE on accept, FETCH on last byte or flush.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_FETCH;
      ST_FETCH: if (flush || last) state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched PC and issue/receive byte counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= '0;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
    end else if (accept) begin
      pc_q      <= req_pc;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
    end else if (flush) begin
      issue_cnt <= '0;
      rcv_cnt   <= '0;
    end else begin
      if (issue) issue_cnt <= issue_cnt + 1'b1;
      if (cap)   rcv_cnt   <= rcv_cnt + 1'b1;
    end
  end

  // RAM address/enable, return tracking and fetch responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_a     <= '0;
      mem_rd_en <= 1'b0;
      pend_q    <= 1'b0;
      almost_q  <= 1'b0;
      ok        <= 1'b0;
      dt        <= '0;
      ipc       <= '0;
      busy      <= 1'b0;
    end else begin
      mem_rd_en <= issue;
      if (issue) begin
        mem_a <= pc_q + ADDR_W'(issue_cnt);
      end
      pend_q   <= mem_rd_en & ~flush;
      almost_q <= mem_rd_en & ~flush
                & (issue_cnt == CNT_FULL);
      ok       <= last;
      // Lane 3 of asm_word is still 0 here; byte 3 comes from din.
      if (last) begin
        dt  <= asm_word
             | {mem_din, {(WORD_W - DATA_W){1'b0}}};
        ipc <= pc_q;
      end
      busy <= (state_d == ST_FETCH);
    end
  end

  word_assembler u_asm (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .cap  (cap),
    .lane (rcv_cnt[1:0]),
    .din  (mem_din),
    .word (asm_word)
  );

endmodule

// File: tb/tb_if_mem_port.sv
// Bench for if_mem_port: RAM model, scoreboard of fetched words.
// Scenarios: reset, basic, stall, flush/back-to-back, wrap, async reset.
module tb_if_mem_port;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] req_pc;
  logic        flush;
  logic        ls_busy;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic        mem_rd_en;
  logic        ok;
  logic        almost_ok;
  logic [31:0] dt;
  logic [31:0] ipc;
  logic        busy;

  typedef struct {
    logic [31:0] dt;
    logic [31:0] ipc;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ram[logic [31:0]];
  int          errs;
  int          checks;
  int          cyc;
  int          ok_seen;

  if_mem_port #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_pc    (req_pc),
    .flush     (flush),
    .ls_busy   (ls_busy),
    .mem_din   (mem_din),
    .mem_a     (mem_a),
    .mem_rd_en (mem_rd_en),
    .ok        (ok),
    .almost_ok (almost_ok),
    .dt        (dt),
    .ipc       (ipc),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ram_byte(
    input logic [31:0] a
  );
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction

  function automatic logic [31:0] exp_word(
    input logic [31:0] pc
  );
    logic [31:0] w;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = pc + 32'(i);
      w[i*8 +: 8] = ram_byte(a);
    end
    return w;
  endfunction

  // RAM: data for the address seen at an edge appears next cycle.
  always @(posedge clk) mem_din <= ram_byte(mem_a);

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input int c);
    exp_t e;
    e.dt  = exp_word(pc);
    e.ipc = pc;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && sb.size() != 0; i++) step();
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  // Response monitor: every ok must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && ok === 1'b1) begin
        ok_seen++;
        if (sb.size() == 0) begin
          chk("ok_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("ok_dt", 64'(dt), 64'(e.dt));
          chk("ok_ipc", 64'(ipc), 64'(e.ipc));
          chk("ok_cyc", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // One fetch; ls_busy blocks issue edges st_at..st_at+st_len-1.
  task automatic fetch_chk(
    input logic [31:0] pc,
    input int          st_at,
    input int          st_len
  );
    int          t0;
    int          issued;
    logic [31:0] a;
    req    = 1'b1;
    req_pc = pc;
    step();
    req = 1'b0;
    t0  = cyc;
    push(pc, t0 + 6 + st_len);
    chk("acc_busy", 64'(busy), 64'd1);
    issued = 0;
    for (int k = 1; k <= 12 && issued < 4; k++) begin
      ls_busy = (k >= st_at) && (k < st_at + st_len);
      step();
      if (!ls_busy) begin
        a = pc + 32'(issued);
        chk("iss_addr", 64'(mem_a), 64'(a));
        chk("iss_rd", 64'(mem_rd_en), 64'd1);
        issued++;
      end else begin
        chk("stall_rd", 64'(mem_rd_en), 64'd0);
      end
    end
    ls_busy = 1'b0;
    chk("pre_almost", 64'(almost_ok), 64'd0);
    step();
    chk("almost", 64'(almost_ok), 64'd1);
    chk("almost_rd", 64'(mem_rd_en), 64'd0);
    step();
    chk("ok_busy", 64'(busy), 64'd0);
    drain(4);
  endtask

  initial begin
    int t0;
    int t1;
    int okc;
    errs    = 0;
    checks  = 0;
    cyc     = 0;
    ok_seen = 0;
    ram[32'h0000_1000] = 8'h13;
    ram[32'h0000_1001] = 8'h05;
    ram[32'h0000_1002] = 8'h10;
    ram[32'h0000_1003] = 8'h00;

    // Reset held with random inputs.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req     = 1'($urandom);
      req_pc  = $urandom;
      flush   = 1'($urandom);
      ls_busy = 1'($urandom);
      step();
      chk("rst_mem_a", 64'(mem_a), 64'd0);
      chk("rst_ctl", 64'({mem_rd_en, ok, almost_ok, busy}),
          64'd0);
      chk("rst_dt", 64'(dt), 64'd0);
      chk("rst_ipc", 64'(ipc), 64'd0);
    end
    req     = 1'b0;
    req_pc  = '0;
    flush   = 1'b0;
    ls_busy = 1'b0;
    rst     = 1'b1;
    step();

    // Basic fetch, then stalled fetch of the same word.
    fetch_chk(32'h0000_1000, 0, 0);
    chk("basic_dt", 64'(dt), 64'h0010_0513);
    fetch_chk(32'h0000_1000, 3, 2);
    chk("stall_dt", 64'(dt), 64'h0010_0513);

    // Flush mid-fetch, back-to-back accept in ok cycle.
    okc    = ok_seen;
    req    = 1'b1;
    req_pc = 32'h0000_3000;
    step();
    req = 1'b0;
    t0  = cyc;
    step();
    step();
    flush = 1'b1;
    step();
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_rd", 64'(mem_rd_en), 64'd0);
    flush  = 1'b0;
    req    = 1'b1;
    req_pc = 32'h0000_2000;
    step();
    req = 1'b0;
    t1  = cyc;
    chk("re_acc_cyc", 64'(t1 - t0), 64'd4);
    chk("re_acc_busy", 64'(busy), 64'd1);
    push(32'h0000_2000, t1 + 6);
    repeat (5) step();
    chk("flush_no_ok", 64'(ok_seen - okc), 64'd0);
    chk("b2b_almost", 64'(almost_ok), 64'd1);
    step();
    chk("b2b_ok", 64'(ok), 64'd1);
    chk("b2b_idle", 64'(busy), 64'd0);
    req    = 1'b1;
    req_pc = 32'h0000_2400;
    step();
    req = 1'b0;
    chk("b2b_acc", 64'(busy), 64'd1);
    push(32'h0000_2400, t1 + 13);
    drain(20);

    // Address wrap.
    fetch_chk(32'hFFFF_FFFE, 0, 0);
    fetch_chk(32'h0000_40A7, 2, 1);

    // Async reset mid-fetch.
    req    = 1'b1;
    req_pc = 32'h0000_5000;
    step();
    req = 1'b0;
    repeat (4) step();
    #2 rst = 1'b0;
    #1;
    chk("arst_mem_a", 64'(mem_a), 64'd0);
    chk("arst_ctl", 64'({mem_rd_en, ok, almost_ok, busy}),
        64'd0);
    chk("arst_dt", 64'(dt), 64'd0);
    chk("arst_ipc", 64'(ipc), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    okc = ok_seen;
    repeat (10) step();
    chk("arst_no_ok", 64'(ok_seen - okc), 64'd0);
    chk("arst_idle", 64'(busy), 64'd0);

    fetch_chk(32'h0000_1000, 1, 1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
